// File: rtl/bomberman_pkg.sv
// Shared playfield geometry, colours and bomb state encoding for the pixel generators.
// Latency: n/a (constants, types and one combinational helper).
// Backpressure: n/a.
package bomberman_pkg;

    localparam int TILE_SHIFT  = 5;     // 32 px tiles
    localparam int GRID_W      = 20;    // playfield width in tiles
    localparam int GRID_H      = 15;    // playfield height in tiles
    localparam int SPRITE_SIZE = 32;    // player sprite edge in pixels

    localparam logic [11:0] BOMB_COLOR    = 12'h888;
    localparam logic [11:0] EXPLODE_COLOR = 12'hF80;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        EXPLODING = 2'd2
    } bomb_state_t;

    // Tile under the sprite centre, clamped to max_tile. The 11-bit sum keeps
    // a sprite near the right/bottom edge from wrapping back to tile 0.
    function automatic logic [10:0] centre_tile(input logic [9:0]  pos,
                                                input logic [10:0] max_tile);
        logic [10:0] centre;
        logic [10:0] tile;
        centre = {1'b0, pos} + 11'(SPRITE_SIZE / 2);
        tile   = centre >> TILE_SHIFT;
        return (tile > max_tile) ? max_tile : tile;
    endfunction

endpackage

// File: rtl/bomb_controller_if.sv
// Groups the player/pixel inputs and bomb pixel/status outputs of the bomb controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels sampled every clock.
// Ports: place, game_over, b_x/b_y (sprite top-left), v_x/v_y (pixel) in;
//        bomb_rgb/bomb_on, explosion_rgb/explosion_on, bomb_active, exploding,
//        explode_pulse, tile_x, tile_y out.
interface bomb_controller_if;

    logic        place;
    logic        game_over;
    logic [9:0]  b_x;
    logic [9:0]  b_y;
    logic [9:0]  v_x;
    logic [9:0]  v_y;
    logic [11:0] bomb_rgb;
    logic        bomb_on;
    logic [11:0] explosion_rgb;
    logic        explosion_on;
    logic        bomb_active;
    logic        exploding;
    logic        explode_pulse;
    logic [4:0]  tile_x;
    logic [3:0]  tile_y;

    // master: the surrounding game logic; slave: the bomb controller.
    modport master (
        output place, game_over, b_x, b_y, v_x, v_y,
        input  bomb_rgb, bomb_on, explosion_rgb, explosion_on,
               bomb_active, exploding, explode_pulse, tile_x, tile_y
    );

    modport slave (
        input  place, game_over, b_x, b_y, v_x, v_y,
        output bomb_rgb, bomb_on, explosion_rgb, explosion_on,
               bomb_active, exploding, explode_pulse, tile_x, tile_y
    );

endinterface

// File: rtl/bomb_controller_tile_cross_match.sv
// Tests whether a pixel tile is the centre tile or lies on a plus-shaped cross around it.
// Latency: combinational.
// Backpressure: none.
// Ports: px_tx/px_ty pixel tile, ctr_tx/ctr_ty centre tile, range arm length in;
//        centre_hit, cross_hit out.
module tile_cross_match (
    input  logic [5:0] px_tx,
    input  logic [5:0] px_ty,
    input  logic [5:0] ctr_tx,
    input  logic [5:0] ctr_ty,
    input  logic [5:0] range,
    output logic       centre_hit,
    output logic       cross_hit
);

    logic signed [6:0] dx;
    logic signed [6:0] dy;
    logic        [6:0] adx;
    logic        [6:0] ady;

    // Signed differences so a centre at column 0 never reaches the far column.
    always_comb begin
        dx  = $signed({1'b0, px_tx}) - $signed({1'b0, ctr_tx});
        dy  = $signed({1'b0, px_ty}) - $signed({1'b0, ctr_ty});
        adx = (dx < 0) ? $unsigned(-dx) : $unsigned(dx);
        ady = (dy < 0) ? $unsigned(-dy) : $unsigned(dy);

        centre_hit = (px_tx == ctr_tx) && (px_ty == ctr_ty);
        cross_hit  = ((px_ty == ctr_ty) && (adx <= {1'b0, range})) ||
                     ((px_tx == ctr_tx) && (ady <= {1'b0, range}));
    end

endmodule

// File: rtl/bomb_controller.sv
// Places one bomb under the player's sprite centre, runs its fuse, then drives a cross explosion.
// Latency: status flags follow the state register; bomb_on/explosion_on lag v_x/v_y by 1 cycle.
// Backpressure: none; presses while a bomb is live are dropped, game_over aborts to IDLE.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries place, game_over,
//        b_x/b_y, v_x/v_y in and colours, pixel enables, status flags and bomb tile out.
module bomb_controller
    import bomberman_pkg::*;
#(
    parameter int unsigned FUSE_CYCLES    = 300000000,
    parameter int unsigned EXPLODE_CYCLES = 50000000,
    parameter int unsigned EXPLODE_RANGE  = 1,
    parameter int unsigned BLINK_BIT      = 23
) (
    input  logic              clk,
    input  logic              reset,
    bomb_controller_if.slave  bus
);

    bomb_state_t state;
    bomb_state_t next_state;
    logic [31:0] counter;
    logic [31:0] next_counter;
    logic        place_q;
    logic        press;
    logic        tile_load;

    logic [4:0]  tile_x_r;
    logic [3:0]  tile_y_r;
    logic        bomb_on_r;
    logic        explosion_on_r;
    logic        bomb_active_r;
    logic        exploding_r;
    logic        explode_pulse_r;

    logic [5:0]  px_tx;
    logic [5:0]  px_ty;
    logic        visible;
    logic        blank;
    logic        centre_hit;
    logic        cross_hit;

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state   = state;
        next_counter = counter;
        press        = bus.place & ~place_q;
        tile_load    = 1'b0;

        if (bus.game_over) begin
            next_state   = IDLE;
            next_counter = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        next_state   = ARMED;
                        next_counter = 32'(FUSE_CYCLES - 1);
                        tile_load    = 1'b1;
                    end
                end
                ARMED: begin
                    if (counter == '0) begin
                        next_state   = EXPLODING;
                        next_counter = 32'(EXPLODE_CYCLES - 1);
                    end else begin
                        next_counter = counter - 32'd1;
                    end
                end
                EXPLODING: begin
                    if (counter == '0) begin
                        next_state = IDLE;
                    end else begin
                        next_counter = counter - 32'd1;
                    end
                end
                default: begin
                    next_state   = IDLE;
                    next_counter = '0;
                end
            endcase
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            place_q <= 1'b0;
        end else begin
            state   <= next_state;
            counter <= next_counter;
            place_q <= bus.place;
        end
    end

    // ---------------- pixel decode ----------------
    always_comb begin
        px_tx   = 6'(bus.v_x >> TILE_SHIFT);
        px_ty   = 6'(bus.v_y >> TILE_SHIFT);
        visible = (bus.v_x < 10'(GRID_W << TILE_SHIFT)) &&
                  (bus.v_y < 10'(GRID_H << TILE_SHIFT));
        // Blink only in the last quarter of the fuse.
        blank   = (counter < 32'(FUSE_CYCLES / 4)) && counter[BLINK_BIT];
    end

    tile_cross_match u_cross (
        .px_tx      (px_tx),
        .px_ty      (px_ty),
        .ctr_tx     ({1'b0, tile_x_r}),
        .ctr_ty     ({2'b00, tile_y_r}),
        .range      (6'(EXPLODE_RANGE)),
        .centre_hit (centre_hit),
        .cross_hit  (cross_hit)
    );

    // ---------------- registered outputs ----------------
    // Status flags decode next_state so they line up with the state register;
    // the tile registers survive game_over so consumers keep the last position.
    always_ff @(posedge clk) begin
        if (reset) begin
            tile_x_r        <= '0;
            tile_y_r        <= '0;
            bomb_on_r       <= 1'b0;
            explosion_on_r  <= 1'b0;
            bomb_active_r   <= 1'b0;
            exploding_r     <= 1'b0;
            explode_pulse_r <= 1'b0;
        end else begin
            if (tile_load) begin
                tile_x_r <= 5'(centre_tile(bus.b_x, 11'(GRID_W - 1)));
                tile_y_r <= 4'(centre_tile(bus.b_y, 11'(GRID_H - 1)));
            end
            bomb_active_r   <= (next_state == ARMED);
            exploding_r     <= (next_state == EXPLODING);
            explode_pulse_r <= (state == ARMED) && (next_state == EXPLODING);
            bomb_on_r       <= ~bus.game_over && (state == ARMED) && visible &&
                               centre_hit && ~blank;
            explosion_on_r  <= ~bus.game_over && (state == EXPLODING) && visible &&
                               cross_hit;
        end
    end

    assign bus.bomb_rgb      = BOMB_COLOR;
    assign bus.explosion_rgb = EXPLODE_COLOR;
    assign bus.bomb_on       = bomb_on_r;
    assign bus.explosion_on  = explosion_on_r;
    assign bus.bomb_active   = bomb_active_r;
    assign bus.exploding     = exploding_r;
    assign bus.explode_pulse = explode_pulse_r;
    assign bus.tile_x        = tile_x_r;
    assign bus.tile_y        = tile_y_r;

endmodule

// File: tb/tb_bomb_controller.sv
// Self-checking bench for bomb_controller: directed lifecycle/pixel scenarios plus random traffic.
// Latency: reference model predicts flags per cycle and pixel enables one cycle after v_x/v_y.
// Backpressure: n/a.
module tb_bomb_controller;
    import bomberman_pkg::*;

    localparam int F  = 20;   // fuse cycles
    localparam int E  = 8;    // explosion cycles
    localparam int R  = 1;    // explosion arm length
    localparam int BB = 1;    // blink bit

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bomb_controller_if bif();

    bomb_controller #(
        .FUSE_CYCLES    (F),
        .EXPLODE_CYCLES (E),
        .EXPLODE_RANGE  (R),
        .BLINK_BIT      (BB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a bomb is described only by the cycle its fuse starts.
    int cyc     = 0;
    int m_start = -1000000;
    int m_tx    = 0;
    int m_ty    = 0;
    bit m_pq    = 0;
    bit exp_bon = 0;
    bit exp_eon = 0;

    int n_act, n_expl, n_pulse, n_bon;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_armed(input int c);
        return (c - m_start >= 0) && (c - m_start < F);
    endfunction

    function automatic bit is_expl(input int c);
        return (c - m_start >= F) && (c - m_start < F + E);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int tile_of(input int pos, input int max_tile);
        int t;
        t = (pos + SPRITE_SIZE / 2) / 32;
        return (t > max_tile) ? max_tile : t;
    endfunction

    // One clock: update the model from the inputs sampled at this edge, then check.
    task automatic tick();
        int pc, rem, ptx, pty;
        bit pa, pe, vis, go;
        @(posedge clk);
        pc  = cyc;
        cyc = cyc + 1;
        pa  = is_armed(pc);
        pe  = is_expl(pc);
        go  = bif.game_over;
        if (reset) begin
            m_start = -1000000;
            m_tx = 0; m_ty = 0; m_pq = 0;
            exp_bon = 0; exp_eon = 0;
        end else begin
            vis = (int'(bif.v_x) < GRID_W * 32) && (int'(bif.v_y) < GRID_H * 32);
            ptx = int'(bif.v_x) / 32;
            pty = int'(bif.v_y) / 32;
            rem = F - 1 - (pc - m_start);   // fuse cycles still to run
            exp_bon = !go && pa && vis && ptx == m_tx && pty == m_ty &&
                      !((rem < F / 4) && (((rem >> BB) & 1) == 1));
            exp_eon = !go && pe && vis &&
                      ((pty == m_ty && iabs(ptx - m_tx) <= R) ||
                       (ptx == m_tx && iabs(pty - m_ty) <= R));
            if (go) begin
                m_start = -1000000;
            end else if (bif.place && !m_pq && !pa && !pe) begin
                m_start = cyc;
                m_tx = tile_of(int'(bif.b_x), GRID_W - 1);
                m_ty = tile_of(int'(bif.b_y), GRID_H - 1);
            end
            m_pq = bif.place;
        end
        #1;
        check_eq("bomb_active",   32'(bif.bomb_active),   32'(is_armed(cyc)));
        check_eq("exploding",     32'(bif.exploding),     32'(is_expl(cyc)));
        check_eq("explode_pulse", 32'(bif.explode_pulse), 32'(cyc - m_start == F));
        check_eq("bomb_on",       32'(bif.bomb_on),       32'(exp_bon));
        check_eq("explosion_on",  32'(bif.explosion_on),  32'(exp_eon));
        check_eq("tile_x",        32'(bif.tile_x),        32'(m_tx));
        check_eq("tile_y",        32'(bif.tile_y),        32'(m_ty));
        check_eq("bomb_rgb",      32'(bif.bomb_rgb),      32'h888);
        check_eq("explosion_rgb", 32'(bif.explosion_rgb), 32'hF80);
        n_act   += int'(bif.bomb_active);
        n_expl  += int'(bif.exploding);
        n_pulse += int'(bif.explode_pulse);
        n_bon   += int'(bif.bomb_on);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        n_act = 0; n_expl = 0; n_pulse = 0; n_bon = 0;
    endtask

    task automatic press_at(input int x, input int y);
        bif.b_x = 10'(x);
        bif.b_y = 10'(y);
        bif.place = 1'b1;
        tick();
        bif.place = 1'b0;
    endtask

    task automatic wait_exploding();
        for (int i = 0; i < 60 && !bif.exploding; i++) tick();
        check_eq("wait_exploding", 32'(bif.exploding), 32'd1);
    endtask

    task automatic pixel_check(input string tag, input int x, input int y, input bit exp);
        bif.v_x = 10'(x);
        bif.v_y = 10'(y);
        tick();
        check_eq(tag, 32'(bif.explosion_on), 32'(exp));
    endtask

    int vx, vy;

    initial begin
        reset = 1'b1;
        bif.place = 0; bif.game_over = 0;
        bif.b_x = 0; bif.b_y = 0; bif.v_x = 10'd1000; bif.v_y = 10'd1000;
        clear_counts();
        ticks(3);
        check_eq("reset_active", 32'(bif.bomb_active), 32'd0);
        check_eq("reset_tile_x", 32'(bif.tile_x), 32'd0);
        reset = 1'b0;
        ticks(2);

        // Placement timing and tile latch
        press_at(100, 60);                                  // now cycle N+1
        check_eq("t_active_first", 32'(bif.bomb_active), 32'd1);
        check_eq("t_tile_x", 32'(bif.tile_x), 32'd3);
        check_eq("t_tile_y", 32'(bif.tile_y), 32'd2);
        ticks(19);                                          // N+20
        check_eq("t_active_last", 32'(bif.bomb_active), 32'd1);
        check_eq("t_pulse_early", 32'(bif.explode_pulse), 32'd0);
        tick();                                             // N+21
        check_eq("t_pulse", 32'(bif.explode_pulse), 32'd1);
        check_eq("t_expl_first", 32'(bif.exploding), 32'd1);
        check_eq("t_active_off", 32'(bif.bomb_active), 32'd0);
        tick();
        check_eq("t_pulse_once", 32'(bif.explode_pulse), 32'd0);
        ticks(6);                                           // N+28
        check_eq("t_expl_last", 32'(bif.exploding), 32'd1);
        tick();                                             // N+29
        check_eq("t_idle", 32'(bif.exploding), 32'd0);
        ticks(2);

        // Clamp at the right/bottom edges
        press_at(630, 470);
        check_eq("clamp_x", 32'(bif.tile_x), 32'd19);
        check_eq("clamp_y", 32'(bif.tile_y), 32'd14);
        ticks(32);

        // Held button fires once; press during ARMED is dropped
        clear_counts();
        bif.b_x = 10'd100; bif.b_y = 10'd60;
        bif.place = 1'b1;
        ticks(50);
        bif.place = 1'b0;
        ticks(5);
        check_eq("hold_one_pulse", 32'(n_pulse), 32'd1);
        check_eq("hold_active_len", 32'(n_act), 32'd20);
        clear_counts();
        press_at(100, 60);
        ticks(5);
        press_at(300, 300);
        ticks(40);
        check_eq("retrig_active_len", 32'(n_act), 32'd20);
        check_eq("retrig_expl_len", 32'(n_expl), 32'd8);
        check_eq("retrig_pulses", 32'(n_pulse), 32'd1);
        check_eq("retrig_tile_x", 32'(bif.tile_x), 32'd3);

        // Blink: bomb tile visible for all fuse counts except 3 and 2
        clear_counts();
        bif.v_x = 10'd100; bif.v_y = 10'd70;
        press_at(100, 60);
        ticks(30);
        check_eq("blink_on_cycles", 32'(n_bon), 32'd18);

        // Explosion cross around (3,2)
        press_at(100, 60);
        wait_exploding();
        pixel_check("cross_left",  64,  64, 1'b1);
        pixel_check("cross_far",   160, 64, 1'b0);
        pixel_check("cross_up",    96,  32, 1'b1);
        pixel_check("cross_diag",  128, 96, 1'b0);
        ticks(12);

        // Clipping at grid origin
        press_at(0, 0);
        wait_exploding();
        pixel_check("clip_far_col", 608, 0, 1'b0);
        pixel_check("clip_right",   32,  0, 1'b1);
        pixel_check("clip_down",    0,  32, 1'b1);
        pixel_check("clip_far_row", 0, 448, 1'b0);
        ticks(12);

        // game_over mid-ARMED, and game_over beating a press
        clear_counts();
        press_at(200, 200);
        ticks(5);
        bif.game_over = 1'b1;
        tick();
        check_eq("go_active", 32'(bif.bomb_active), 32'd0);
        check_eq("go_pulse",  32'(bif.explode_pulse), 32'd0);
        bif.place = 1'b1;
        tick();
        bif.game_over = 1'b0;
        bif.place = 1'b0;
        ticks(30);
        check_eq("go_no_pulse", 32'(n_pulse), 32'd0);

        // reset mid-EXPLODING
        press_at(100, 60);
        wait_exploding();
        ticks(2);
        reset = 1'b1;
        tick();
        check_eq("rst_expl", 32'(bif.exploding), 32'd0);
        check_eq("rst_eon",  32'(bif.explosion_on), 32'd0);
        check_eq("rst_tile", 32'(bif.tile_x), 32'd0);
        reset = 1'b0;
        tick();

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7, 0) == 0) bif.place = ~bif.place;
            bif.game_over = ($urandom_range(149, 0) == 0);
            reset         = ($urandom_range(399, 0) == 0);
            if ($urandom_range(15, 0) == 0) begin
                bif.b_x = 10'($urandom_range(1023, 0));
                bif.b_y = 10'($urandom_range(1023, 0));
            end
            if ($urandom_range(1, 0) == 0) begin
                bif.v_x = 10'($urandom_range(1023, 0));
                bif.v_y = 10'($urandom_range(1023, 0));
            end else begin
                vx = m_tx * 32 + int'($urandom_range(159, 0)) - 64;
                vy = m_ty * 32 + int'($urandom_range(159, 0)) - 64;
                bif.v_x = 10'((vx < 0) ? 0 : vx);
                bif.v_y = 10'((vy < 0) ? 0 : vy);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bomb_controller.md
Name: bomb_controller

Overview:
Bomb lifecycle and pixel-generation stage that sits beside the player block and feeds the top-level colour mux.
- Takes the player position and the debounced centre button, and places one bomb on the tile under the player's sprite centre.
- Counts down a fuse, then drives a cross-shaped explosion for a fixed time.
- Produces bomb_rgb/bomb_on and explosion_rgb/explosion_on for the current VGA pixel, plus tile and status outputs for the wall, enemy and player logic.

Parameters:
TILE_SHIFT, 5, log2 of tile size in pixels (32 px tiles)
GRID_W, 20, playfield width in tiles
GRID_H, 15, playfield height in tiles
SPRITE_SIZE, 32, player sprite edge in pixels; bomb tile uses sprite centre
FUSE_CYCLES, 300000000, ARMED duration in clk cycles (3 s at 100 MHz)
EXPLODE_CYCLES, 50000000, EXPLODING duration in clk cycles
EXPLODE_RANGE, 1, explosion arm length in tiles in each direction
BLINK_BIT, 23, remaining-count bit that gates the blink in the final fuse quarter
BOMB_COLOR, 12'h888, bomb colour word
EXPLODE_COLOR, 12'hF80, explosion colour word

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
place  in  1  debounced centre-button level
game_over  in  1  high = abort and hold IDLE
b_x  in  10  player sprite top-left x, in pixels
b_y  in  10  player sprite top-left y, in pixels
v_x  in  10  current pixel hCount
v_y  in  10  current pixel vCount
bomb_rgb  out  12  bomb colour
bomb_on  out  1  current pixel shows the bomb
explosion_rgb  out  12  explosion colour
explosion_on  out  1  current pixel lies in the explosion cross
bomb_active  out  1  state is ARMED (tile occupied, blocks movement)
exploding  out  1  state is EXPLODING
explode_pulse  out  1  one cycle, on the first EXPLODING cycle
tile_x  out  5  bomb tile column
tile_y  out  4  bomb tile row

Behaviour:
- Clock and reset: clk only. reset is synchronous and active-high, and has priority over everything. Reset values:
  - state = IDLE
  - counter = 0, place_q = 0
  - tile_x = tile_y = 0
  - bomb_on = explosion_on = bomb_active = exploding = explode_pulse = 0
- Colour outputs: bomb_rgb and explosion_rgb are the constants BOMB_COLOR and EXPLODE_COLOR at all times.
- Edge detect: place_q <= place every cycle, in every state. A press event is place & ~place_q. A held button never re-fires.
- States are IDLE, ARMED, EXPLODING.
  - IDLE: on a press with game_over=0:
    - latch tile_x = (b_x + SPRITE_SIZE/2) >> TILE_SHIFT and tile_y = (b_y + SPRITE_SIZE/2) >> TILE_SHIFT, computed at 11-bit width, then clamped to GRID_W-1 and GRID_H-1;
    - load counter = FUSE_CYCLES-1;
    - go to ARMED.
  - ARMED: the counter decrements each cycle. At counter==0: load EXPLODE_CYCLES-1, go to EXPLODING, and assert explode_pulse on that first EXPLODING cycle.
  - EXPLODING: the counter decrements. At counter==0, go to IDLE.
- Durations: ARMED lasts exactly FUSE_CYCLES cycles and EXPLODING exactly EXPLODE_CYCLES cycles. bomb_active and exploding are registered decodes of the state.
- Ignored presses: presses during ARMED or EXPLODING are dropped, not queued. Only one bomb exists at a time.
- game_over:
  - In any state, forces IDLE on the next cycle and clears all outputs except the tile registers.
  - game_over and a press in the same cycle: game_over wins.
- Pixel path, 1-cycle registered latency from v_x/v_y:
  - px_tx = v_x >> TILE_SHIFT, px_ty = v_y >> TILE_SHIFT.
  - visible = v_x < GRID_W<<TILE_SHIFT and v_y < GRID_H<<TILE_SHIFT.
  - bomb_on = ARMED & visible & px_tx==tile_x & px_ty==tile_y & ~blank.
  - blank = (counter < FUSE_CYCLES/4) & counter[BLINK_BIT].
  - explosion_on = EXPLODING & visible & one of:
    - px_ty==tile_y & |px_tx-tile_x| <= EXPLODE_RANGE, or
    - px_tx==tile_x & |px_ty-tile_y| <= EXPLODE_RANGE.
  - Compute the differences signed, with no wrap.
- Grid edges: the cross clips at the grid edge. A bomb at tile (0,0) must not light column GRID_W-1 or row GRID_H-1.
- Walls: walls do not stop the explosion in this revision. Wall and enemy consumers use exploding, tile_x and tile_y themselves.
- Counter: 32 bits, never wraps. It is only ever loaded or decremented toward zero.

Decomposition:
- bomberman_pkg holds:
  - TILE_SHIFT, GRID_W, GRID_H, SPRITE_SIZE;
  - the colour constants;
  - the bomb state encoding (IDLE=0, ARMED=1, EXPLODING=2).
- Other pixel generators (breakable wall, enemy) share the same package.
- One sub-module is natural: tile_cross_match. It is combinational: inputs are the pixel tile, the centre tile and the range; outputs are centre_hit and cross_hit. The wall block will reuse it for destruction.

Test Plan:
Run with FUSE_CYCLES=20, EXPLODE_CYCLES=8, BLINK_BIT=1.
- Placement timing: reset, b_x=100, b_y=60, pulse place at cycle N:
  - bomb_active=1 over N+1 to N+20;
  - explode_pulse=1 at N+21 only;
  - exploding=1 over N+21 to N+28;
  - IDLE at N+29.
- Tile latch: b_x=100, b_y=60 -> tile_x=3, tile_y=2. b_x=630 -> tile_x clamped to 19.
- Retrigger and hold: hold place high for 50 cycles -> exactly one bomb. Press again during ARMED -> ignored, timing unchanged.
- Explosion cross: bomb at (3,2), EXPLODING:
  - pixel (64,64) (tile 2,2) -> explosion_on=1;
  - (160,64) (tile 5,2) -> 0;
  - (96,32) -> 1;
  - (128,96) (diagonal) -> 0;
  - each result appears one cycle after the pixel.
- Blink and clipping:
  - bomb at (0,0), EXPLODING: pixel (608,0) -> explosion_on=0.
  - ARMED counter in 0..4: bomb_on follows ~counter[1] on the bomb tile.
- game_over and reset: assert game_over mid-ARMED -> IDLE next cycle, all flags 0, no explode_pulse. Assert reset mid-EXPLODING -> all outputs 0 next cycle.
